// File: rtl/send_queue_if.sv
// ---------------------------------------------------------------------------
// send_queue_if
// Handshake bundle between a byte producer, the send queue and the UART
// sender that drains it.
//   in_data/in_len/in_valid/in_ready : producer push of 1..4 bytes
//   flush                            : discard everything queued
//   out_data/out_valid/out_ready     : head byte towards the UART sender
//   level/almost_full                : occupancy status
// master : producer/consumer side (drives requests, observes status)
// slave  : the queue itself
// ---------------------------------------------------------------------------
interface send_queue_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [31:0]         in_data;
  logic [1:0]          in_len;
  logic                in_valid;
  logic                in_ready;
  logic                flush;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready;
  logic [DEPTH_LOG2:0] level;
  logic                almost_full;

  modport master (
    output in_data, in_len, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, level, almost_full
  );

  modport slave (
    input  in_data, in_len, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, level, almost_full
  );
endinterface

// File: rtl/send_queue.sv
// ---------------------------------------------------------------------------
// send_queue
// Byte FIFO in front of a UART sender. A producer pushes 1..4 bytes per
// cycle (most significant byte first); the sender pops one byte per cycle.
//   CLK   : single clock, rising edge
//   RST_N : synchronous active-low reset (pointers and level only)
//   bus   : send_queue_if.slave (push port, pop port, flush, status)
// ---------------------------------------------------------------------------
module send_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic         CLK,
  input  logic         RST_N,
  send_queue_if.slave  bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;   // level width
  localparam int FW    = DEPTH_LOG2 + 2;   // headroom width for free-space math

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [LW-1:0]         r_level;

  logic [FW-1:0]         w_free;
  logic [FW-1:0]         w_need;
  logic [2:0]            w_n;
  logic                  w_push;
  logic                  w_pop;
  logic [LW-1:0]         w_level_add;
  logic [LW-1:0]         w_level_sub;
  logic [7:0]            w_slot_byte [4];
  logic [3:0]            w_slot_en;

  // Space check uses the registered level only, so a pop in the same
  // cycle never makes room for this cycle's push.
  assign w_n    = {1'b0, bus.in_len} + 3'd1;
  assign w_free = FW'(DEPTH) - {1'b0, r_level};
  assign w_need = {{DEPTH_LOG2{1'b0}}, bus.in_len} + FW'(1);

  assign bus.in_ready    = !bus.flush && (w_free >= w_need);
  assign w_push          = bus.in_valid && bus.in_ready;
  assign w_pop           = (r_level != '0) && bus.out_ready && !bus.flush;

  assign bus.out_valid   = (r_level != '0);
  assign bus.out_data    = r_mem[r_rd_ptr];
  assign bus.level       = r_level;
  assign bus.almost_full = (r_level >= LW'(AF_LEVEL));

  assign w_level_add = w_push ? LW'(w_n) : '0;
  assign w_level_sub = w_pop  ? LW'(1)   : '0;

  // Slot j (offset from write pointer) receives byte (in_len - j), so the
  // most significant offered byte lands first in queue order.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_slot_en[j]   = 1'b0;
      w_slot_byte[j] = 8'h00;
    end
    for (int j = 0; j < 4; j++) begin
      logic [1:0] w_sel;
      w_sel          = bus.in_len - 2'(j);
      w_slot_en[j]   = (j <= int'(bus.in_len));
      w_slot_byte[j] = bus.in_data[{w_sel, 3'b000} +: 8];
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (RST_N && w_push) begin
      for (int j = 0; j < 4; j++) begin
        if (w_slot_en[j]) begin
          r_mem[r_wr_ptr + DEPTH_LOG2'(j)] <= w_slot_byte[j];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(w_n);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      r_level <= r_level + w_level_add - w_level_sub;
    end
  end

endmodule

// File: tb/tb_send_queue.sv
module tb_send_queue;

  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic CLK;
  logic RST_N;

  send_queue_if #(.DEPTH_LOG2(DL2)) u_if ();

  send_queue #(.DEPTH_LOG2(DL2), .AF_LEVEL(AF)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: the queue content as a plain byte queue.
  byte unsigned mq[$];
  bit model_on = 0;

  logic       c_rstn, c_fl, c_vld, c_ordy;
  logic [1:0] c_len;
  logic [31:0] c_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic rstn, input logic fl, input logic vld,
                        input logic [1:0] len, input logic [31:0] d, input logic ordy);
    c_rstn = rstn; c_fl = fl; c_vld = vld; c_len = len; c_d = d; c_ordy = ordy;
    RST_N           = rstn;
    u_if.flush      = fl;
    u_if.in_valid   = vld;
    u_if.in_len     = len;
    u_if.in_data    = d;
    u_if.out_ready  = ordy;
    #1;
  endtask

  task automatic model_check();
    int sz;
    bit rdy;
    if (!model_on) return;
    sz  = mq.size();
    rdy = !c_fl && ((DEPTH - sz) >= (int'(c_len) + 1));
    chk("m_level", 32'(u_if.level), 32'(sz));
    chk("m_out_valid", 32'(u_if.out_valid), 32'(sz != 0));
    if (sz != 0) chk("m_out_data", 32'(u_if.out_data), 32'(mq[0]));
    chk("m_almost_full", 32'(u_if.almost_full), 32'(sz >= AF));
    chk("m_in_ready", 32'(u_if.in_ready), 32'(rdy));
  endtask

  task automatic tick();
    bit rdy;
    if (!c_rstn || c_fl) begin
      mq.delete();
    end else begin
      rdy = (DEPTH - mq.size()) >= (int'(c_len) + 1);
      if (mq.size() > 0 && c_ordy) void'(mq.pop_front());
      if (c_vld && rdy)
        for (int k = int'(c_len); k >= 0; k--) mq.push_back(c_d[8*k +: 8]);
    end
    @(posedge CLK);
    #1;
    if (!c_rstn) model_on = 1;
  endtask

  typedef struct {
    logic rstn, fl, vld;
    logic [1:0] len;
    logic [31:0] d;
    logic ordy;
    logic cmp;
    logic [4:0] lvl;
    logic ovld;
    logic [7:0] od;
    logic rdy;
    logic af;
  } vec_t;

  vec_t tbl[17];
  byte unsigned got[$];

  initial begin
    // rstn fl vld len data ordy | cmp lvl ovld od rdy af   (expected before the edge)
    tbl[0]  = '{0,0,0,2'd0,32'h0,       0, 0, 5'd0,  0,8'h00,1,0};
    tbl[1]  = '{1,0,1,2'd3,32'h41424344,0, 1, 5'd0,  0,8'h00,1,0};
    tbl[2]  = '{1,0,0,2'd0,32'h0,       1, 1, 5'd4,  1,8'h41,1,0};
    tbl[3]  = '{1,0,0,2'd0,32'h0,       1, 1, 5'd3,  1,8'h42,1,0};
    tbl[4]  = '{1,0,0,2'd0,32'h0,       1, 1, 5'd2,  1,8'h43,1,0};
    tbl[5]  = '{1,0,0,2'd0,32'h0,       1, 1, 5'd1,  1,8'h44,1,0};
    tbl[6]  = '{1,0,0,2'd0,32'h0,       0, 1, 5'd0,  0,8'h00,1,0};
    tbl[7]  = '{1,0,1,2'd3,32'h00010203,0, 1, 5'd0,  0,8'h00,1,0};
    tbl[8]  = '{1,0,1,2'd3,32'h04050607,0, 1, 5'd4,  1,8'h00,1,0};
    tbl[9]  = '{1,0,1,2'd3,32'h08090a0b,0, 1, 5'd8,  1,8'h00,1,0};
    tbl[10] = '{1,0,1,2'd3,32'h0c0d0e0f,0, 1, 5'd12, 1,8'h00,1,1};
    tbl[11] = '{1,0,0,2'd0,32'h0,       0, 1, 5'd16, 1,8'h00,0,1};
    tbl[12] = '{1,0,0,2'd0,32'h0,       1, 1, 5'd16, 1,8'h00,0,1};
    tbl[13] = '{1,0,0,2'd0,32'h0,       0, 1, 5'd15, 1,8'h01,1,1};
    tbl[14] = '{1,0,0,2'd1,32'h0,       0, 1, 5'd15, 1,8'h01,0,1};
    tbl[15] = '{1,0,1,2'd0,32'h000000aa,1, 1, 5'd15, 1,8'h01,1,1};
    tbl[16] = '{1,0,0,2'd0,32'h0,       0, 1, 5'd15, 1,8'h02,1,1};

    set_in(0, 0, 0, 2'd0, 32'h0, 0);
    tick();

    // Directed table: basic push/drain, fill to full, pop at full, push+pop at 15.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].rstn, tbl[i].fl, tbl[i].vld, tbl[i].len, tbl[i].d, tbl[i].ordy);
      model_check();
      if (tbl[i].cmp) begin
        chk($sformatf("t%0d_level", i), 32'(u_if.level), 32'(tbl[i].lvl));
        chk($sformatf("t%0d_out_valid", i), 32'(u_if.out_valid), 32'(tbl[i].ovld));
        if (tbl[i].ovld) chk($sformatf("t%0d_out_data", i), 32'(u_if.out_data), 32'(tbl[i].od));
        chk($sformatf("t%0d_in_ready", i), 32'(u_if.in_ready), 32'(tbl[i].rdy));
        chk($sformatf("t%0d_almost_full", i), 32'(u_if.almost_full), 32'(tbl[i].af));
      end
      tick();
    end

    // Drain: 02..0f then the byte pushed at level 15 must be last.
    for (int i = 0; i < 15; i++) begin
      set_in(1, 0, 0, 2'd0, 32'h0, 1);
      model_check();
      chk("drain_data", 32'(u_if.out_data), (i < 14) ? 32'(8'h02 + i) : 32'haa);
      tick();
    end
    set_in(1, 0, 0, 2'd0, 32'h0, 0);
    model_check();
    chk("drain_empty_valid", 32'(u_if.out_valid), 32'd0);
    chk("drain_empty_level", 32'(u_if.level), 32'd0);

    // Flush at level 9 with a push offered in the same cycle.
    tick();
    set_in(1, 0, 1, 2'd3, 32'h11223344, 0); model_check(); tick();
    set_in(1, 0, 1, 2'd3, 32'h55667788, 0); model_check(); tick();
    set_in(1, 0, 1, 2'd0, 32'h00000099, 0); model_check(); tick();
    set_in(1, 1, 1, 2'd3, 32'hdeadbeef, 1);
    model_check();
    chk("flush_pre_level", 32'(u_if.level), 32'd9);
    chk("flush_in_ready", 32'(u_if.in_ready), 32'd0);
    tick();
    set_in(1, 0, 0, 2'd0, 32'h0, 0);
    model_check();
    chk("flush_level", 32'(u_if.level), 32'd0);
    chk("flush_out_valid", 32'(u_if.out_valid), 32'd0);
    tick();
    chk("flush_nostore", 32'(u_if.out_valid), 32'd0);

    // Reset at level 7 with pop and push requested.
    set_in(1, 0, 1, 2'd3, 32'ha1a2a3a4, 0); model_check(); tick();
    set_in(1, 0, 1, 2'd2, 32'h00b1b2b3, 0); model_check(); tick();
    set_in(0, 0, 1, 2'd3, 32'hc1c2c3c4, 1);
    chk("rst_pre_level", 32'(u_if.level), 32'd7);
    tick();
    set_in(1, 0, 0, 2'd3, 32'h0, 0);
    model_check();
    chk("rst_level", 32'(u_if.level), 32'd0);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("rst_almost_full", 32'(u_if.almost_full), 32'd0);
    tick();

    // Wrap-around: 40 single bytes interleaved with pops, bounded cycle budget.
    begin
      int nxt = 0;
      int cyc = 0;
      got.delete();
      while (got.size() < 40 && cyc < 400) begin
        logic ordy;
        ordy = (cyc % 3) != 0;
        set_in(1, 0, nxt < 40, 2'd0, 32'(nxt), ordy);
        model_check();
        if (u_if.out_valid && ordy) got.push_back(u_if.out_data);
        if (nxt < 40 && u_if.in_ready) nxt++;
        tick();
        cyc++;
      end
      chk("wrap_count", 32'(got.size()), 32'd40);
      for (int i = 0; i < got.size() && i < 40; i++)
        chk($sformatf("wrap_%0d", i), 32'(got[i]), 32'(i));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      logic ordy;
      ordy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      set_in($urandom_range(0, 199) != 0, $urandom_range(0, 79) == 0,
             $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, ordy);
      model_check();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
